// File: rtl/frame_assembler56.sv
// Purpose : aligns a byte stream on a start-of-frame marker and collects NBYTES data bytes plus an XOR checksum byte into one frame word.
// Latency : out_valid rises on the edge that accepts the checksum byte, so it is visible one cycle after that byte.
// Backpressure: while a finished frame waits for out_ready, in_ready is low. in_ready returns high the cycle after delivery.
module frame_assembler56 #(
    parameter int NBYTES = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [8*NBYTES-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_chk_ok,
    output logic [3:0]            byte_cnt,
    output logic                  err_sync,
    output logic [7:0]            frame_cnt
);

    localparam int          LP_W  = 8 * NBYTES;
    localparam logic [3:0]  LP_NB = 4'(NBYTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHK     = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [LP_W-1:0]     r_shift;
    logic [LP_W-1:0]     w_shift_nxt;
    logic [7:0]          r_xor;
    logic [7:0]          w_xor_nxt;
    logic [3:0]          r_byte_cnt;
    logic [3:0]          w_byte_cnt_nxt;
    logic [LP_W-1:0]     r_out_data;
    logic [LP_W-1:0]     w_out_data_nxt;
    logic                r_out_chk_ok;
    logic                w_out_chk_ok_nxt;
    logic                r_err_sync;
    logic                w_err_sync_nxt;
    logic [7:0]          r_frame_cnt;
    logic [7:0]          w_frame_cnt_nxt;

    logic                w_accept;
    logic                w_deliver;

    // The input side is closed while a frame is parked waiting for downstream.
    assign in_ready   = rst_n && (r_state != HOLD);
    assign out_valid  = (r_state == HOLD);
    assign w_accept   = in_valid && in_ready;
    assign w_deliver  = out_valid && out_ready;

    assign out_data   = r_out_data;
    assign out_chk_ok = r_out_chk_ok;
    assign byte_cnt   = r_byte_cnt;
    assign err_sync   = r_err_sync;
    assign frame_cnt  = r_frame_cnt;

    // State register; reset drops any partial or held frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update for the framing sequence.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_xor_nxt        = r_xor;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_out_data_nxt   = r_out_data;
        w_out_chk_ok_nxt = r_out_chk_ok;
        w_err_sync_nxt   = r_err_sync;
        w_frame_cnt_nxt  = r_frame_cnt;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_shift_nxt    = {{(LP_W-8){1'b0}}, in_data};
                        w_xor_nxt      = in_data;
                        w_byte_cnt_nxt = 4'd1;
                        w_state_nxt    = COLLECT;
                    end else begin
                        // Byte outside any frame: drop it and flag loss of alignment.
                        w_err_sync_nxt = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (w_accept) begin
                    if (in_sof) begin
                        // A new marker aborts the partial frame and starts over on this byte.
                        w_shift_nxt    = {{(LP_W-8){1'b0}}, in_data};
                        w_xor_nxt      = in_data;
                        w_byte_cnt_nxt = 4'd1;
                        w_err_sync_nxt = 1'b1;
                    end else begin
                        w_shift_nxt    = {r_shift[LP_W-9:0], in_data};
                        w_xor_nxt      = r_xor ^ in_data;
                        w_byte_cnt_nxt = r_byte_cnt + 4'd1;
                        if (r_byte_cnt + 4'd1 == LP_NB) begin
                            w_state_nxt = CHK;
                        end
                    end
                end
            end

            CHK: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_shift_nxt    = {{(LP_W-8){1'b0}}, in_data};
                        w_xor_nxt      = in_data;
                        w_byte_cnt_nxt = 4'd1;
                        w_err_sync_nxt = 1'b1;
                        w_state_nxt    = COLLECT;
                    end else begin
                        // This byte is the checksum; it is compared, not stored.
                        w_out_data_nxt   = r_shift;
                        w_out_chk_ok_nxt = (in_data == r_xor);
                        w_state_nxt      = HOLD;
                    end
                end
            end

            HOLD: begin
                if (w_deliver) begin
                    w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    w_byte_cnt_nxt  = 4'd0;
                    w_state_nxt     = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_xor        <= 8'd0;
            r_byte_cnt   <= 4'd0;
            r_out_data   <= '0;
            r_out_chk_ok <= 1'b0;
            r_err_sync   <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_shift      <= w_shift_nxt;
            r_xor        <= w_xor_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_chk_ok <= w_out_chk_ok_nxt;
            r_err_sync   <= w_err_sync_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_frame_assembler56.sv
// Purpose : directed checks of frame_assembler56 at NBYTES=7 against hand-computed frames.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: out_ready is held low for a few cycles in one scenario.
module tb_frame_assembler56;

    localparam int NB = 7;
    localparam logic [55:0] CLEAN_WORD = 56'h01020408102040;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic [8*NB-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_chk_ok;
    logic [3:0]        byte_cnt;
    logic              err_sync;
    logic [7:0]        frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] clean_bytes [NB] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    frame_assembler56 #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chk_ok (out_chk_ok),
        .byte_cnt   (byte_cnt),
        .err_sync   (err_sync),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one byte and hold it until the assembler can take it.
    task automatic send_byte(input logic [7:0] d, input logic sof);
        int k;
        @(negedge clk);
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready) begin
            k++;
            if (k > 50) begin
                check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic gap();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic toggle, input logic [7:0] ck);
        for (int i = 0; i < NB; i++) begin
            send_byte(clean_bytes[i], (i == 0));
            if (toggle) gap();
        end
        send_byte(ck, 1'b0);
    endtask

    // Assumes out_ready=1: the frame is visible one cycle and gone the next.
    task automatic check_frame(input string tag, input logic exp_ok, input logic [7:0] exp_cnt);
        gap();
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_data"}, 64'(out_data), 64'(CLEAN_WORD));
        check_eq({tag, "_chk_ok"}, 64'(out_chk_ok), 64'(exp_ok));
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_byte_cnt"}, 64'(byte_cnt), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_chk_ok", 64'(out_chk_ok), 64'd0);
        check_eq("rst_byte_cnt", 64'(byte_cnt), 64'd0);
        check_eq("rst_err_sync", 64'(err_sync), 64'd0);
        check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Clean frame
        for (int i = 0; i < NB; i++) send_byte(clean_bytes[i], (i == 0));
        gap();
        check_eq("clean_byte_cnt_full", 64'(byte_cnt), 64'd7);
        check_eq("clean_no_early_valid", 64'(out_valid), 64'd0);
        send_byte(8'h7F, 1'b0);
        check_frame("clean", 1'b1, 8'd1);
        check_eq("clean_err_sync", 64'(err_sync), 64'd0);

        // Bad checksum still delivered and counted
        send_frame(1'b0, 8'h7E);
        check_frame("badck", 1'b0, 8'd2);

        // Backpressure: downstream stalls five cycles
        out_ready = 1'b0;
        send_frame(1'b0, 8'h7F);
        gap();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check_eq($sformatf("bp_valid_%0d", c), 64'(out_valid), 64'd1);
            check_eq($sformatf("bp_data_%0d", c), 64'(out_data), 64'(CLEAN_WORD));
            check_eq($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
        end
        check_eq("bp_frame_cnt_held", 64'(frame_cnt), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_valid_drop", 64'(out_valid), 64'd0);
        check_eq("bp_in_ready_back", 64'(in_ready), 64'd1);
        check_eq("bp_frame_cnt", 64'(frame_cnt), 64'd3);

        // Resync: aborted partial frame then a clean one
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        gap();
        check_eq("resync_partial_cnt", 64'(byte_cnt), 64'd3);
        check_eq("resync_no_err_yet", 64'(err_sync), 64'd0);
        send_frame(1'b0, 8'h7F);
        check_frame("resync", 1'b1, 8'd4);
        check_eq("resync_err_sync", 64'(err_sync), 64'd1);

        // Idle garbage, then a frame with in_valid toggling
        do_reset();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        gap();
        check_eq("garbage_err_sync", 64'(err_sync), 64'd1);
        check_eq("garbage_byte_cnt", 64'(byte_cnt), 64'd0);
        check_eq("garbage_out_valid", 64'(out_valid), 64'd0);
        send_frame(1'b1, 8'h7F);
        check_frame("stall", 1'b1, 8'd1);
        check_eq("stall_err_sticky", 64'(err_sync), 64'd1);

        // Reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(clean_bytes[i], (i == 0));
        gap();
        check_eq("midrst_byte_cnt_pre", 64'(byte_cnt), 64'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_byte_cnt", 64'(byte_cnt), 64'd0);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_err_sync", 64'(err_sync), 64'd0);
        check_eq("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        send_frame(1'b0, 8'h7F);
        check_frame("midrst", 1'b1, 8'd1);
        check_eq("midrst_err_after", 64'(err_sync), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_assembler56.md
Name: frame_assembler56

Overview:
Upstream byte-framing stage for the 56-bit byte-shift/readback register. Accepts a byte stream over a valid/ready handshake and aligns it on a start-of-frame marker. Collects NBYTES data bytes plus one XOR checksum byte, then presents the assembled word with a checksum verdict on a valid/ready output. Downstream stage consumes out_data as a complete frame instead of free-running ui_in shifts.

Parameters:
NBYTES, 7, data bytes per frame (legal range 2..8); frame word width = 8*NBYTES (56 at default)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_data  input  8  incoming byte
in_valid  input  1  in_data valid
in_sof  input  1  qualifies in_data as first byte of a frame
in_ready  output  1  assembler accepts a byte this cycle
out_data  output  8*NBYTES  assembled frame; first received byte in the top byte, last data byte in [7:0]
out_valid  output  1  frame available
out_ready  input  1  downstream accepts frame
out_chk_ok  output  1  received checksum byte equals XOR of the data bytes; valid while out_valid=1
byte_cnt  output  4  data bytes collected in the current frame
err_sync  output  1  sticky: a byte was dropped in IDLE, or a frame was aborted by a new in_sof
frame_cnt  output  8  frames delivered (out handshakes), wraps 255->0

Behaviour:
- Reset: rst_n is synchronous, active-low, on clk. Outputs: state=IDLE, out_data=0, out_valid=0, out_chk_ok=0, byte_cnt=0, err_sync=0, frame_cnt=0, running XOR=0.
- Reset is accepted mid-frame or mid-hold: the partial or held frame is discarded and not counted.
- in_ready = rst_n AND (state != HOLD). It is combinational from state.
- Accept = in_valid AND in_ready. Deliver = out_valid AND out_ready.
- States: IDLE, COLLECT, CHK, HOLD.
- IDLE
  - Accept with in_sof=1: shift reg = {0.., in_data}, xor = in_data, byte_cnt = 1, then COLLECT.
  - Accept with in_sof=0: byte dropped, err_sync <= 1.
- COLLECT
  - Accept with in_sof=1: restart exactly as in IDLE, and err_sync <= 1.
  - Accept with in_sof=0: shift reg = {reg[8*NBYTES-9:0], in_data}, xor ^= in_data, byte_cnt++.
  - When byte_cnt becomes NBYTES, go to CHK.
- CHK
  - Accept with in_sof=1: restart as in IDLE, err_sync <= 1.
  - Accept with in_sof=0: the byte is the checksum.
    - out_data <= shift reg; out_chk_ok <= (in_data == xor).
    - out_valid <= 1; state goes to HOLD.
- HOLD
  - out_valid=1. out_data and out_chk_ok are held stable until Deliver.
  - On Deliver: out_valid <= 0, frame_cnt++, byte_cnt <= 0, then IDLE.
  - in_ready=1 from the next cycle.
- Latency: out_valid rises on the clock edge that accepts the checksum byte, i.e. visible in the following cycle.
- Peak throughput: one frame per NBYTES+2 cycles (NBYTES+1 bytes plus one delivery cycle).
- out_data retains its last value after Deliver. out_data is meaningful only while out_valid=1.
- Bad checksum frames are still delivered with out_chk_ok=0 and counted in frame_cnt. Drop policy belongs to the downstream stage.
- in_valid=0 in any state: no state change. Stall of any length is allowed.
- in_sof is ignored when in_valid=0.
- err_sync clears only on reset.

Test Plan:
- Clean frame: sof+01, then 02, 04, 08, 10, 20, 40, then checksum 7F, out_ready=1 → out_valid for 1 cycle; out_data=0x01020408102040; out_chk_ok=1; frame_cnt=1; err_sync=0.
- Bad checksum: same frame with checksum 7E → out_data identical, out_chk_ok=0, frame_cnt increments.
- Backpressure: out_ready=0 for 5 cycles after frame completes → out_valid and out_data stable, in_ready=0 for all 5; out_ready=1 → delivery, in_ready=1 next cycle.
- Resync: sof+AA, BB, CC, then sof+01 and the clean frame above → err_sync=1; the delivered frame is 0x01020408102040 with out_chk_ok=1; no frame is delivered for AA..CC.
- Idle garbage and stalls: bytes 55, 66 without sof in IDLE → dropped, err_sync=1, byte_cnt=0; then the clean frame with in_valid toggled every other cycle → the same result as the clean-frame case.
- Reset mid-frame: rst_n=0 for 1 cycle after 4 data bytes → byte_cnt=0, out_valid=0, err_sync=0, frame_cnt=0; the next clean frame is delivered correctly.
